// File: rtl/bcd_subtractor_serial.sv
`default_nettype none
// ============================================================================
// Module   : bcd_subtractor_serial
// Brief    : Digit-serial packed-BCD subtractor (A - B), LSD first, rippled
//            borrow, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_subtractor_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   Diff,
    output logic                  Borrow,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  shadow_q, shadow_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          borrow_q, borrow_d;
    logic [W-1:0]  diff_q, diff_d;
    logic          borrow_out_q, borrow_out_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic [DIGITS-1:0] nibble_bad;
    logic              operands_bad;
    logic              last_digit;
    logic [3:0]        a_digit;
    logic [3:0]        b_digit;
    logic [4:0]        t_raw;
    logic [3:0]        digit_out;

    // Operand validation is done on the live inputs at the accepting edge.
    for (genvar g = 0; g < DIGITS; g++) begin : g_check
        assign nibble_bad[g] = (A[4*g +: 4] > 4'd9) || (B[4*g +: 4] > 4'd9);
    end

    assign operands_bad = |nibble_bad;
    assign last_digit   = (idx_q == IW'(DIGITS - 1));

    // One digit per cycle; t_raw[4] is the sign of a_i - b_i - borrow.
    always_comb begin
        a_digit   = a_q[4*int'(idx_q) +: 4];
        b_digit   = b_q[4*int'(idx_q) +: 4];
        t_raw     = {1'b0, a_digit} - {1'b0, b_digit} - {4'b0000, borrow_q};
        digit_out = t_raw[4] ? (t_raw[3:0] + 4'd10) : t_raw[3:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !operands_bad) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_digit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == S_RUN);
    end

    // Datapath next-state: visible results only change on completion.
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        borrow_d     = borrow_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        err_d        = err_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    shadow_d = '0;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    if (operands_bad) begin
                        err_d        = 1'b1;
                        diff_d       = '0;
                        borrow_out_d = 1'b0;
                        done_d       = 1'b1;
                    end
                end
            end
            S_RUN: begin
                shadow_d[4*int'(idx_q) +: 4] = digit_out;
                borrow_d = t_raw[4];
                idx_d    = idx_q + IW'(1);
                if (last_digit) begin
                    diff_d       = shadow_d;
                    borrow_out_d = t_raw[4];
                    err_d        = 1'b0;
                    done_d       = 1'b1;
                    idx_d        = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            shadow_q     <= '0;
            idx_q        <= '0;
            borrow_q     <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            borrow_q     <= borrow_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    assign done   = done_q;
    assign Diff   = diff_q;
    assign Borrow = borrow_out_q;
    assign err    = err_q;

endmodule
`default_nettype wire
